// File: rtl/md_sequencer_if.sv
// Issue/status bundle between the pipeline and the HI/LO multiply-divide sequencer.
// MDU_ABORT_EN adds the abort request line.
interface md_sequencer_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic [6:0]  d_ura_rs;
  logic [6:0]  d_ura_rt;
  logic        d_is_md;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        state_dbg;
`ifdef MDU_ABORT_EN
  logic        abort;

  modport master (output start, op, a, b, cancel, d_ura_rs, d_ura_rt, d_is_md, abort,
                  input  busy, stall, hi, lo, state_dbg);
  modport slave  (input  start, op, a, b, cancel, d_ura_rs, d_ura_rt, d_is_md, abort,
                  output busy, stall, hi, lo, state_dbg);
`else
  modport master (output start, op, a, b, cancel, d_ura_rs, d_ura_rt, d_is_md,
                  input  busy, stall, hi, lo, state_dbg);
  modport slave  (input  start, op, a, b, cancel, d_ura_rs, d_ura_rt, d_is_md,
                  output busy, stall, hi, lo, state_dbg);
`endif
endinterface

// File: rtl/md_sequencer.sv
// HI/LO multiply-divide sequencer: computes at issue, holds the result pending, commits after a fixed latency.
// Optional MDU_ABORT_EN: abort input discards an in-flight operation.
// Issue handshake: an op is taken on any edge where start & ~cancel & op<=5 in IDLE; stall holds D off while busy.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_sequencer_if.slave md
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   pend_hi, pend_lo;
  logic          pend_wr;
  logic [31:0]   hi_r, lo_r;

  logic          acc, md_go, is_div, div_zero, hilo_use, abort_req, last;
  logic          sgn_m, sgn_d;
  logic [63:0]   ext_a, ext_b, res;
  logic [31:0]   mag_a, mag_b, div_b, uq, ur, sq, sr;

`ifdef MDU_ABORT_EN
  assign abort_req = md.abort;
`else
  assign abort_req = 1'b0;
`endif

  always_comb begin
    acc      = md.start & ~md.cancel & (md.op <= 3'd5);
    md_go    = acc & (md.op <= 3'd3);
    is_div   = md.op[1];
    div_zero = (md.b == 32'd0);
    hilo_use = md.d_is_md | (md.d_ura_rs[6:1] == 6'b100000) | (md.d_ura_rt[6:1] == 6'b100000);
    last     = (cnt == CW'(1));
  end

  // One 64-bit multiplier; signed MULT is the same product of sign-extended operands.
  // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no special case.
  always_comb begin
    sgn_m = (md.op == 3'd0);
    sgn_d = (md.op == 3'd2);
    ext_a = {{32{sgn_m & md.a[31]}}, md.a};
    ext_b = {{32{sgn_m & md.b[31]}}, md.b};
    mag_a = (sgn_d && md.a[31]) ? (~md.a + 32'd1) : md.a;
    mag_b = (sgn_d && md.b[31]) ? (~md.b + 32'd1) : md.b;
    div_b = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uq    = mag_a / div_b;
    ur    = mag_a % div_b;
    sq    = (sgn_d && (md.a[31] ^ md.b[31])) ? (~uq + 32'd1) : uq;
    sr    = (sgn_d && md.a[31]) ? (~ur + 32'd1) : ur;
    res   = is_div ? {sr, sq} : (ext_a * ext_b);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (md_go) state_nxt = BUSY;
      BUSY: if (abort_req || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (md_go) begin
            pend_hi <= res[63:32];
            pend_lo <= res[31:0];
            pend_wr <= ~(is_div & div_zero);
            cnt     <= is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          end else if (acc && md.op == 3'd4) begin
            hi_r <= md.a;
          end else if (acc && md.op == 3'd5) begin
            lo_r <= md.a;
          end
        end
        BUSY: begin
          if (abort_req) begin
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            pend_wr <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
            if (last && pend_wr) begin
              hi_r <= pend_hi;
              lo_r <= pend_lo;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign md.busy      = (state == BUSY);
  assign md.stall     = hilo_use & ((state == BUSY) | md_go);
  assign md.hi        = hi_r;
  assign md.lo        = lo_r;
  assign md.state_dbg = state;
endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed and random ops against an arithmetic reference model, commit scoreboard.
// Define MDU_ABORT_EN for the abort variant of the mid-operation test.
module tb_md_sequencer;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_sequencer_if m();
  md_sequencer #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(m.slave));

  logic [63:0] exp_q[$];
  int          len_q[$];
  int          cmp_cnt = 0;
  int          fail_cnt = 0;
  logic [31:0] m_hi, m_lo;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural effect of an accepted op on HI/LO.
  function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          p, sa, sb;
    logic [63:0]     pu;
    case (op)
      3'd0: begin
        p = longint'($signed(a)) * longint'($signed(b));
        m_hi = 32'(p >>> 32);
        m_lo = 32'(p);
      end
      3'd1: begin
        pu = {32'd0, a} * {32'd0, b};
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      3'd2: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        m_lo = 32'(sa / sb);
        m_hi = 32'(sa % sb);
      end
      3'd3: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endfunction

  // Monitor: every busy run that ends without reset/abort must be an expected commit.
  int   run_len = 0;
  logic busy_prev = 1'b0;
  logic discard;
  always @(negedge clk) begin
    discard = reset;
`ifdef MDU_ABORT_EN
    discard = discard | m.abort;
`endif
    if (m.busy && m.start) check("protocol_start_while_busy", 64'd1, 64'd0);
    if (discard) begin
      busy_prev = 1'b0;
      run_len   = 0;
    end else if (m.busy) begin
      busy_prev = 1'b1;
      run_len++;
    end else if (busy_prev) begin
      busy_prev = 1'b0;
      if (exp_q.size() == 0) begin
        check("unexpected_commit", 64'd1, 64'd0);
      end else begin
        check("commit_hilo", {m.hi, m.lo}, exp_q.pop_front());
        check("busy_len", 64'(run_len), 64'(len_q.pop_front()));
      end
      run_len = 0;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic cancel, input logic [6:0] rs, input logic [6:0] rt, input logic ismd);
    logic acc, go, use_hl;
    int   n;
    acc    = !cancel && (op <= 3'd5);
    go     = acc && (op <= 3'd3);
    use_hl = ismd || (rs == 7'h40) || (rs == 7'h41) || (rt == 7'h40) || (rt == 7'h41);
    @(posedge clk); #1;
    m.start = 1'b1; m.op = op; m.a = a; m.b = b; m.cancel = cancel;
    m.d_ura_rs = rs; m.d_ura_rt = rt; m.d_is_md = ismd;
    @(negedge clk);
    check("stall_accept", 64'(m.stall), 64'(use_hl && go));
    check("busy_accept", 64'(m.busy), 64'd0);
    if (acc) model_op(op, a, b);
    if (go) begin
      exp_q.push_back({m_hi, m_lo});
      len_q.push_back((op <= 3'd1) ? MC : DC);
    end
    @(posedge clk); #1;
    m.start = 1'b0; m.cancel = 1'b0;
    if (go) begin
      n = 0;
      forever begin
        @(negedge clk);
        if (!m.busy) break;
        check("stall_busy", 64'(m.stall), 64'(use_hl));
        n++;
        if (n > DC + 5) begin
          check("busy_timeout", 64'd1, 64'd0);
          break;
        end
      end
      check("stall_after", 64'(m.stall), 64'd0);
    end else begin
      @(negedge clk);
      check("busy_idle", 64'(m.busy), 64'd0);
      check("hilo_idle", {m.hi, m.lo}, {m_hi, m_lo});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  r_op;
    logic [31:0] r_a, r_b;
    logic [6:0]  ura_set [5];
    ura_set = '{7'h00, 7'h40, 7'h41, 7'h05, 7'h42};

    reset = 1'b1;
    m.start = 1'b0; m.op = '0; m.a = '0; m.b = '0; m.cancel = 1'b0;
    m.d_ura_rs = '0; m.d_ura_rt = '0; m.d_is_md = 1'b1;
`ifdef MDU_ABORT_EN
    m.abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    check("reset_busy", 64'(m.busy), 64'd0);
    check("reset_stall", 64'(m.stall), 64'd0);
    check("reset_hilo", {m.hi, m.lo}, 64'd0);
    check("reset_state", 64'(m.state_dbg), 64'd0);

    issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0, 7'h00, 7'h00, 1'b0);
    check("mult_neg", {m.hi, m.lo}, 64'hFFFFFFFF_FFFFFFFA);
    issue(3'd3, 32'd100, 32'd7, 1'b0, 7'h00, 7'h41, 1'b0);
    check("divu_100_7", {m.hi, m.lo}, {32'd2, 32'd14});
    issue(3'd4, 32'h12345678, 32'd0, 1'b0, 7'h00, 7'h00, 1'b0);
    check("mthi", {m.hi, m.lo}, {32'h12345678, 32'd14});
    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 7'h40, 7'h00, 1'b0);
    check("div_neg7_2", {m.hi, m.lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'd2, 32'd5, 32'd0, 1'b0, 7'h00, 7'h00, 1'b1);
    check("div_by_zero", {m.hi, m.lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'd0, 32'd9, 32'd9, 1'b1, 7'h00, 7'h00, 1'b1);
    check("cancel_no_change", {m.hi, m.lo}, 64'hFFFFFFFF_FFFFFFFD);
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 7'h00, 7'h00, 1'b0);
    check("div_overflow", {m.hi, m.lo}, {32'd0, 32'h80000000});
    issue(3'd5, 32'hCAFEF00D, 32'd0, 1'b0, 7'h00, 7'h00, 1'b1);
    issue(3'd6, 32'hDEADBEEF, 32'd1, 1'b0, 7'h00, 7'h00, 1'b1);

    repeat (40) begin
      r_op = 3'($urandom_range(0, 7));
      r_a  = $urandom;
      case ($urandom_range(0, 5))
        0:       r_b = 32'd0;
        1:       r_b = 32'($urandom_range(1, 20));
        2:       r_b = 32'hFFFFFFFF;
        default: r_b = $urandom;
      endcase
      issue(r_op, r_a, r_b, ($urandom_range(0, 7) == 0),
            ura_set[$urandom_range(0, 4)], ura_set[$urandom_range(0, 4)], ($urandom_range(0, 3) == 0));
    end

    // MULTU interrupted at busy cycle 3; no commit may follow.
    @(posedge clk); #1;
    m.start = 1'b1; m.op = 3'd1; m.a = 32'hFFFFFFFF; m.b = 32'hFFFFFFFF; m.cancel = 1'b0;
    m.d_ura_rs = '0; m.d_ura_rt = '0; m.d_is_md = 1'b0;
    @(posedge clk); #1;
    m.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`ifdef MDU_ABORT_EN
    m.abort = 1'b1;
`else
    reset = 1'b1;
`endif
    @(negedge clk);
    check("mid_busy_c3", 64'(m.busy), 64'd1);
    @(negedge clk);
`ifndef MDU_ABORT_EN
    m_hi = '0; m_lo = '0;
`endif
    check("mid_busy_cleared", 64'(m.busy), 64'd0);
    check("mid_hilo", {m.hi, m.lo}, {m_hi, m_lo});
    @(posedge clk); #1;
`ifdef MDU_ABORT_EN
    m.abort = 1'b0;
`else
    reset = 1'b0;
`endif
    repeat (MC + 3) begin
      @(negedge clk);
      check("no_late_busy", 64'(m.busy), 64'd0);
      check("no_late_commit", {m.hi, m.lo}, {m_hi, m_lo});
    end

    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 7'h00, 7'h00, 1'b0);
    check("multu_max", {m.hi, m.lo}, 64'hFFFFFFFE_00000001);

    @(posedge clk);
    @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule

// File: doc/md_sequencer.md
Name: md_sequencer

Overview:
Controls the HI/LO multiply-divide resource of the pipelined core.
- Accepts mult/div/mthi/mtlo from the E stage and computes the result.
- Holds that result in a pending register, then commits it to HI/LO after a fixed per-class latency.
- Raises the D-stage stall while a D-stage instruction touches HI/LO, using the unified register addresses (URA) of that instruction's RS/RT: HI = 7'b1000000, LO = 7'b1000001.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
start  input  1  E-stage instruction is an MD op
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
a  input  32  rs operand
b  input  32  rt operand
cancel  input  1  exception/flush at E; suppresses start this cycle
d_ura_rs  input  7  URA of D-stage RS
d_ura_rt  input  7  URA of D-stage RT
d_is_md  input  1  D-stage instruction is mult/div/mthi/mtlo
busy  output  1  operation in flight
stall  output  1  stall request to D stage
hi  output  32  architectural HI
lo  output  32  architectural LO

Behaviour:
- Reset: hi=0, lo=0, busy=0, stall=0, state IDLE, counter=0, pending registers=0.
- Accepted start: acc = start & ~cancel & (op <= 5). Reserved ops and cancelled starts have no effect.
- FSM states: IDLE and BUSY.
- IDLE + acc with op 0-3:
  - Compute the 64-bit result from a,b and latch it into pend_hi/pend_lo.
  - Load counter with MULT_CYCLES (op 0,1) or DIV_CYCLES (op 2,3); go to BUSY.
- IDLE + acc with op 4/5: hi<=a (MTHI) or lo<=a (MTLO) at that edge; stay IDLE; busy stays 0.
- BUSY: counter decrements each edge.
- BUSY with counter==1 at an edge:
  - hi<=pend_hi, lo<=pend_lo; go to IDLE.
  - busy is therefore high for exactly N cycles after the accept edge.
  - The new HI/LO are visible on the cycle busy first reads 0.
- start while BUSY cannot occur, because stall blocks the issue. If it occurs anyway it is ignored; the bench flags it as a protocol error.
- Arithmetic:
  - MULT: signed 32x32 -> {hi,lo}. MULTU: unsigned.
  - DIV: lo=quotient, hi=remainder, truncating toward zero; remainder takes the sign of a. DIVU: unsigned.
  - Divide by zero: the full DIV_CYCLES latency still applies, but HI/LO are left unchanged at commit.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- hilo_use = d_is_md | d_ura_rs in {7'b1000000, 7'b1000001} | d_ura_rt in {7'b1000000, 7'b1000001}.
- stall = hilo_use & (busy | (acc & op<=3)), combinational. This covers the same cycle a mult/div is accepted.
- cancel has no effect on an operation already in BUSY; that operation completes and commits.
- reset mid-operation: returns to IDLE and discards pending; hi/lo go to 0.

Optional Feature:
MDU_ABORT_EN
- Defined: adds input port abort (1 bit).
  - abort=1 while BUSY: next edge returns to IDLE, pending discarded, hi/lo unchanged, busy=0.
  - abort in IDLE is ignored.
  - abort has priority over a same-edge commit (counter==1), so there is no commit.
- Undefined: port absent; in-flight operations always complete.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE(-2), b=3:
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - stall=0 throughout with d_ura_* = 0.
- DIVU a=100, b=7 with D-stage d_ura_rt=7'b1000001 (mflo) held:
  - stall=1 from the accept cycle through all 10 busy cycles, then 0.
  - lo=14, hi=2.
- MTHI a=0x12345678 from IDLE: hi=0x12345678 the next cycle, busy never asserted, lo unchanged.
- DIV a=-7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIV by b=0 → HI/LO unchanged after 10 busy cycles.
- start=1 with cancel=1, op=MULT, d_is_md=1 → no state change, busy=0, stall=0.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with synchronous reset asserted at busy cycle 3:
  - IDLE, hi=lo=0 after the reset edge, no later commit.
  - With MDU_ABORT_EN defined instead: abort at busy cycle 3 leaves the prior hi/lo unchanged.
